fetch_pc_unit: RTL

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pc_pkg.sv | 26 ++
 rtl/fetch_bht.sv | 50 +++++
 rtl/fetch_pc_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the fetch PC unit: icode constants and the
// 2-bit saturating predictor counter type.
package fetch_pc_pkg;

    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] IJXX  = 4'h7;
    localparam logic [3:0] ICALL = 4'h8;
    localparam logic [3:0] IRET  = 4'h9;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_RESET = 2'b10;

    // Saturating step toward 2'b11 when taken, toward 2'b00 otherwise.
    function automatic ctr_t ctr_update(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken && cur != 2'b11) begin
            nxt = cur + 2'b01;
        end else if (!taken && cur != 2'b00) begin
            nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_bht.sv
// Branch history table: 2^IDX_W two-bit saturating counters, combinational
// read of the counter MSB, one update per cycle from the resolving branch.
module fetch_bht
    import fetch_pc_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             pred_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] msb;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            ctr_t ctr_q;
            ctr_t ctr_d;

            always_comb begin
                ctr_d = ctr_q;
                if (upd_en && upd_idx == IDX_W'(gi)) begin
                    ctr_d = ctr_update(ctr_q, upd_taken);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ctr_q <= CTR_RESET;
                end else begin
                    ctr_q <= ctr_d;
                end
            end

            assign msb[gi] = ctr_q[1];
        end
    endgenerate

    // Reads see the registered counter, so a same-index update this cycle
    // is not visible until the next one.
    assign pred_taken = msb[rd_idx];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC selection and next-PC prediction.
// Optional build macro FETCH_PC_BHT_EN enables the fetch_bht direction predictor.
module fetch_pc_unit
    import fetch_pc_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                BHT_IDX_W = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              F_stall,
    input  logic [3:0]        f_icode,
    input  logic [3:0]        f_ifun,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    input  logic [3:0]        M_icode,
    input  logic [3:0]        M_ifun,
    input  logic              M_cnd,
    input  logic              M_pred_taken,
    input  logic [ADDR_W-1:0] M_pc,
    input  logic [ADDR_W-1:0] M_valC,
    input  logic [ADDR_W-1:0] M_valP,
    input  logic [3:0]        W_icode,
    input  logic [ADDR_W-1:0] W_valM,
    output logic [ADDR_W-1:0] f_pc,
    output logic [ADDR_W-1:0] F_predPC,
    output logic              f_pred_taken,
    output logic              f_redirect
);

    logic [ADDR_W-1:0] pred_pc_q;
    logic [ADDR_W-1:0] pred_pc_d;
    logic              m_cond_jxx;
    logic              mispredict;
    logic              cond_pred;

    assign m_cond_jxx = (M_icode == IJXX) && (M_ifun != 4'h0);
    assign mispredict = m_cond_jxx && (M_cnd != M_pred_taken);

    always_comb begin
        f_pc       = pred_pc_q;
        f_redirect = 1'b0;
        if (mispredict) begin
            f_pc       = M_cnd ? M_valC : M_valP;
            f_redirect = 1'b1;
        end else if (W_icode == IRET) begin
            f_pc       = W_valM;
            f_redirect = 1'b1;
        end
    end

`ifdef FETCH_PC_BHT_EN
    fetch_bht #(
        .IDX_W(BHT_IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (f_pc[BHT_IDX_W-1:0]),
        .pred_taken(cond_pred),
        .upd_en    (m_cond_jxx),
        .upd_idx   (M_pc[BHT_IDX_W-1:0]),
        .upd_taken (M_cnd)
    );
`else
    // Static predict-taken; the index width and M_pc have no consumer.
    logic [BHT_IDX_W-1:0] unused_idx_w;
    assign unused_idx_w = '0;
    assign cond_pred    = 1'b1;
`endif

    // Only the low index bits of M_pc feed the table, if at all.
    logic [ADDR_W-1:0] unused_m_pc;
    assign unused_m_pc = M_pc;

    always_comb begin
        f_pred_taken = 1'b0;
        if (f_icode == IJXX) begin
            f_pred_taken = (f_ifun == 4'h0) ? 1'b1 : cond_pred;
        end
    end

    always_comb begin
        pred_pc_d = pred_pc_q;
        if (!F_stall) begin
            if (f_icode == ICALL || (f_icode == IJXX && f_pred_taken)) begin
                pred_pc_d = f_valC;
            end else begin
                pred_pc_d = f_valP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_pc_q <= RESET_PC;
        end else begin
            pred_pc_q <= pred_pc_d;
        end
    end

    assign F_predPC = pred_pc_q;

endmodule
